// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart transmitter between NUM_REQ
// requesters. It accepts one frame at a time and gates each new frame on cts_n.
// It pulses start_tx and then waits for tx_done. The frame is aborted with a
// sticky error flag if tx_done does not arrive within TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cts_n,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       start_tx,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [DATA_W-1:0] win_data;
  int                idx;
  logic              accept;
  logic              wait_done;
  logic              wait_expire;
  logic              frame_end;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_valid[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Select the payload of the current winner
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) win_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  // A tx_done arriving on the expiry cycle takes priority, so that frame still counts as a success
  assign accept      = (state == IDLE) && !cts_n && win_found;
  assign wait_done   = (state == WAIT) && tx_done;
  assign wait_expire = (state == WAIT) && !tx_done && (cnt == CNT_MAX);
  assign frame_end   = wait_done || wait_expire;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; cts_n only matters when choosing to start a new frame
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (frame_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: the accept strobe goes only to the winner, while idle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
    start_tx  = (state == START);
    busy      = (state == START) || (state == WAIT);
  end

  // Latch the winning payload and owner; both are held until the next accept
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data  <= '0;
      grant_id <= '0;
    end else if (accept) begin
      tx_data  <= win_data;
      grant_id <= win_id;
    end
  end

  // Frame timer, pointer advance, completion pulse and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      rr_ptr      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (frame_end) rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      frame_done <= wait_done;
      if (wait_expire)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. The expected (grant_id, tx_data) of each frame is
// queued when stimulus is issued. A monitor pops an entry and compares it on
// every start_tx pulse. Directed checks cover reset, cts_n gating, timeout and
// abort behaviour.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cts_n;
  logic [DATA_W-1:0]         tx_data;
  logic                      start_tx;
  logic                      tx_done;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      frame_done;
  logic                      timeout_err;
  logic                      err_clr;

  logic done_man  = 1'b0;
  logic done_auto = 1'b0;
  bit   auto_en   = 1'b0;

  assign tx_done = done_man | done_auto;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cts_n      (cts_n),
    .tx_data    (tx_data),
    .start_tx   (start_tx),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   failures   = 0;
  int   frame_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance n clock edges and land just after the edge, ready to drive
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each start_tx must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n && start_tx) begin
      if (exp_q.size() == 0) begin
        check("start_tx_without_expectation", 32'(start_tx), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_tx_data", 32'(tx_data), 32'(mon_e.data));
        check("sb_grant_id", 32'(grant_id), 32'(mon_e.id));
      end
    end
    if (frame_done) frame_cnt++;
  end

  // Simple uart model: answers each start_tx with tx_done three cycles later
  always begin
    @(negedge clk);
    if (auto_en && start_tx) begin
      repeat (3) @(posedge clk);
      #1 done_auto = 1'b1;
      @(posedge clk);
      #1 done_auto = 1'b0;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
  endtask

  int accepts;
  int bad;
  int fc0;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    cts_n     = 1'b0;
    err_clr   = 1'b0;
    cyc(1);

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_start_tx", 32'(start_tx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2
    cyc(1);
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    push(2'd2, 8'hA5);
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h4);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    check("t1_start", 32'(start_tx), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    cyc(1);
    @(negedge clk);
    check("t1_start_one_cycle", 32'(start_tx), 32'd0);
    cyc(2);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    @(negedge clk);
    check("t1_frame_done", 32'(frame_done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_tx_data_held", 32'(tx_data), 32'hA5);
    cyc(1);
    @(negedge clk);
    check("t1_frame_done_pulse", 32'(frame_done), 32'd0);

    // Round robin from a fresh pointer with all requesters valid
    cyc(1);
    do_reset();
    fc0       = frame_cnt;
    auto_en   = 1'b1;
    req_data  = 32'h4332_2110;
    req_valid = 4'b1111;
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    push(2'd2, 8'h32);
    push(2'd3, 8'h43);
    push(2'd0, 8'h10);
    accepts = 0;
    for (int c = 0; c < 300 && accepts < 5; c++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) accepts++;
    end
    cyc(1);
    req_valid = '0;
    check("t2_accepts", 32'(accepts), 32'd5);
    cyc(20);
    auto_en = 1'b0;
    check("t2_frames", 32'(frame_cnt - fc0), 32'd5);
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // cts_n holds off new frames
    cts_n     = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h0000_005C;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready != '0 || start_tx || busy) bad++;
    end
    check("t3_hold_off", 32'(bad), 32'd0);
    cyc(1);
    cts_n = 1'b0;
    push(2'd0, 8'h5C);
    @(negedge clk);
    check("t3_ready", 32'(req_ready), 32'h1);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    check("t3_start", 32'(start_tx), 32'd1);
    cyc(1);
    cts_n = 1'b1;
    cyc(2);
    @(negedge clk);
    check("t3_no_abort_on_cts", 32'(busy), 32'd1);
    cyc(1);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    cts_n    = 1'b0;
    @(negedge clk);
    check("t3_frame_done", 32'(frame_done), 32'd1);

    // tx_done during START is ignored
    cyc(1);
    req_valid = 4'b0010;
    req_data  = 32'h0000_3C00;
    push(2'd1, 8'h3C);
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'h2);
    cyc(1);
    req_valid = '0;
    done_man  = 1'b1;
    @(negedge clk);
    check("t6_start", 32'(start_tx), 32'd1);
    cyc(1);
    done_man = 1'b0;
    @(negedge clk);
    check("t6_still_busy", 32'(busy), 32'd1);
    check("t6_no_frame_done", 32'(frame_done), 32'd0);
    cyc(2);
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    @(negedge clk);
    check("t6_frame_done", 32'(frame_done), 32'd1);

    // Timeout with tx_done never returned
    cyc(1);
    req_valid = 4'b0100;
    req_data  = 32'h0077_0000;
    push(2'd2, 8'h77);
    @(negedge clk);
    check("t4_ready", 32'(req_ready), 32'h4);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    check("t4_start", 32'(start_tx), 32'd1);
    repeat (16) @(negedge clk);
    check("t4_err_not_yet", 32'(timeout_err), 32'd0);
    check("t4_busy_before_expiry", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    check("t4_aborted_idle", 32'(busy), 32'd0);
    check("t4_no_frame_done", 32'(frame_done), 32'd0);

    // Pointer advanced past 2; err_clr clears; set wins over a simultaneous clear
    cyc(1);
    req_valid = 4'b1111;
    req_data  = 32'hD4C3_B2A1;
    err_clr   = 1'b1;
    push(2'd3, 8'hD4);
    @(negedge clk);
    check("t4_rr_advanced", 32'(req_ready), 32'h8);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    check("t4_err_cleared", 32'(timeout_err), 32'd0);
    repeat (17) @(negedge clk);
    check("t4_set_wins", 32'(timeout_err), 32'd1);
    cyc(1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_err_clr", 32'(timeout_err), 32'd0);

    // tx_done on the expiry cycle counts as success
    cyc(1);
    req_valid = 4'b0001;
    req_data  = 32'h0000_0099;
    push(2'd0, 8'h99);
    @(negedge clk);
    check("tb_ready", 32'(req_ready), 32'h1);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    repeat (16) @(posedge clk);
    #1 done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    @(negedge clk);
    check("tb_expiry_frame_done", 32'(frame_done), 32'd1);
    check("tb_expiry_no_err", 32'(timeout_err), 32'd0);

    // Reset during WAIT aborts the frame
    cyc(1);
    req_valid = 4'b0011;
    req_data  = 32'h0000_E1F0;
    push(2'd1, 8'hE1);
    @(negedge clk);
    check("t5_ready", 32'(req_ready), 32'h2);
    cyc(1);
    req_valid = '0;
    cyc(2);
    reset_n = 1'b0;
    cyc(1);
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_tx_data", 32'(tx_data), 32'd0);
    check("t5_grant_id", 32'(grant_id), 32'd0);
    check("t5_start_tx", 32'(start_tx), 32'd0);
    cyc(1);
    reset_n  = 1'b1;
    done_man = 1'b1;
    cyc(1);
    done_man = 1'b0;
    @(negedge clk);
    check("t5_no_frame_done", 32'(frame_done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    cyc(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
